// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared store-width codes and memory sizing constants
package mips_mem_pkg;
  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SH  = 2'b01,
    ST_SB  = 2'b10,
    ST_RSV = 2'b11
  } st_op_e;
  localparam logic [3:0] BE_ALL = 4'b1111;
  localparam int ADDR_W_DEF = 10;
endpackage

// File: rtl/store_lane_gen.sv
// store_lane_gen: byte enables, replicated lane data and misalign flag for a store
module store_lane_gen
  import mips_mem_pkg::*;
(
  input  logic [1:0]  st_op,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] lane_data,
  output logic        misalign
);
  // lanes are replicated so the enabled byte positions pick up the right bytes
  always_comb begin
    be        = st_op == ST_SW ? BE_ALL :
                st_op == ST_SH ? (off[1] ? 4'b1100 : 4'b0011) :
                st_op == ST_SB ? 4'b0001 << off : 4'b0000;
    lane_data = st_op == ST_SW ? wdata :
                st_op == ST_SH ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    misalign  = st_op == ST_SW ? |off :
                st_op == ST_SH ? off[0] :
                st_op == ST_SB ? 1'b0 : 1'b1;
  end
endmodule

// File: rtl/dm_store_unit.sv
// dm_store_unit: word-organised data memory with narrowing stores and store address-error capture
module dm_store_unit
  import mips_mem_pkg::*;
#(
  parameter int          ADDR_W = ADDR_W_DEF,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  st_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic [3:0]  be,
  output logic        ades,
  output logic [31:0] bad_addr,
  output logic [31:0] bad_pc,
  output logic [31:0] store_cnt
);
  logic [31:0]       mem [2**ADDR_W];
  logic [31:0]       off;
  logic [ADDR_W-1:0] widx;
  logic              in_range;
  logic [3:0]        lane_be;
  logic [31:0]       lane_data;
  logic              misalign;
  logic              commit;
  logic              fault;

  store_lane_gen u_lane (
    .st_op     (st_op),
    .off       (off[1:0]),
    .wdata     (wdata),
    .be        (lane_be),
    .lane_data (lane_data),
    .misalign  (misalign)
  );

  // address decode, commit/fault qualification and the unbypassed read port
  always_comb begin
    off      = addr - BASE;
    widx     = off[ADDR_W+1:2];
    in_range = off[31:ADDR_W+2] == '0;
    commit   = we && !misalign && in_range;
    fault    = we && !commit;
    be       = commit ? lane_be : 4'b0000;
    rdata    = in_range ? mem[widx] : 32'h0;
  end

  // masked byte-lane write; untouched bytes of the word keep their value
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx][8*i +: 8] <= lane_data[8*i +: 8];
    end
  end

  // fault capture pulses ades for each faulting cycle; counter tracks committed stores
  always_ff @(posedge clk) begin
    if (reset) begin
      ades      <= 1'b0;
      bad_addr  <= '0;
      bad_pc    <= '0;
      store_cnt <= '0;
    end else begin
      ades <= fault;
      if (fault) begin
        bad_addr <= addr;
        bad_pc   <= pc;
      end
      if (commit) store_cnt <= store_cnt + 32'd1;
    end
  end
endmodule

// File: doc/dm_store_unit.md
Name: dm_store_unit

Overview:
- Word-organised data memory with a store-narrowing front end: the write-side counterpart of the immediate/load extender.
- Takes a 32-bit register operand and narrows it to word/halfword/byte lanes (sw/sh/sb).
- Generates byte enables, commits the selected lanes on the clock edge and flags misaligned or out-of-range stores.
- Sits in the MEM stage of the MIPS pipeline, fed by the ALU address and the rt data.

Parameters:
- ADDR_W, 10, log2 of memory depth in 32-bit words (1024 words = 4 KiB).
- BASE, 32'h0000_0000, byte address of word 0.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- we  input  1  store request this cycle.
- st_op  input  2  store width: 2'b00 sw, 2'b01 sh, 2'b10 sb, 2'b11 reserved.
- addr  input  32  byte address from ALU.
- wdata  input  32  rt operand, unaligned (LSB-justified for sh/sb).
- pc  input  32  PC of the storing instruction, captured on fault.
- rdata  output  32  raw word at addr (combinational read).
- be  output  4  byte enables for the current request (combinational, 0 when the request is not committed).
- ades  output  1  one-cycle store address-error pulse, registered.
- bad_addr  output  32  byte address of the last faulting store.
- bad_pc  output  32  PC of the last faulting store.
- store_cnt  output  32  number of committed stores since reset.

Behaviour:
- Reset (sync, active-high, priority over we):
  - all memory words are 0.
  - ades=0, bad_addr=0, bad_pc=0, store_cnt=0.
- Offset: off = addr - BASE.
- Word index: widx = off[ADDR_W+1:2].
- In range: off[31:ADDR_W+2] == 0.
- Lane rules:
  - sw: be=4'b1111; legal iff off[1:0]==0.
  - sh: be = off[1] ? 4'b1100 : 4'b0011; legal iff off[0]==0.
  - sb: be = 4'b0001 << off[1:0]; always aligned.
  - 2'b11: always illegal.
- Lane data:
  - sw: wdata.
  - sh: {2{wdata[15:0]}}.
  - sb: {4{wdata[7:0]}}.
  - Only lanes with be[i]=1 are written; the other bytes of the word are preserved.
- Commit: we && legal && in range → masked write at posedge; store_cnt+1 (wraps at 2^32). be is 0 when the request is not committed.
- Fault: we && (illegal || out of range) →
  - no memory write.
  - At the next posedge: ades=1 for exactly one cycle; bad_addr=addr; bad_pc=pc.
  - Back-to-back faults keep ades high and update bad_addr/bad_pc each cycle.
- Read path:
  - rdata = mem[widx] when in range, else 32'h0. No alignment check on reads.
  - No write-through bypass: a write at edge N is visible on rdata after edge N.
- we=0: no state change except ades returning to 0.
- Reset mid-stream: a store presented in the reset cycle is dropped; ades is not raised.

Decomposition:
- Shared package mips_mem_pkg:
  - ST_SW/ST_SH/ST_SB/ST_RSV codes.
  - BE_ALL constant.
  - The ADDR_W default.
- Sub-module store_lane_gen (purely combinational): st_op, off[1:0] → be, lane data, misalign flag.
- dm_store_unit owns the array, the range check, the fault registers and the counter.

Test Plan:
- Reset then sw addr=0x10 wdata=0x12345678 → be=1111, next cycle rdata@0x10=0x12345678, store_cnt=1, ades=0.
- sb addr=0x11 wdata=0xFFFFFFAB over word 0x12345678 → be=0010, word becomes 0x1234AB78.
- sh addr=0x12 wdata=0x0000BEEF → be=1100, word becomes 0xBEEFAB78; store_cnt=3.
- Misaligned cases:
  - sw addr=0x13 pc=0x3010 → no write, ades=1 for one cycle, bad_addr=0x13, bad_pc=0x3010, store_cnt unchanged.
  - sh addr=0x15 → same fault behaviour.
- Out of range:
  - sw addr=0x1000 (ADDR_W=10) → ades=1, no write.
  - Read of 0x1000 → rdata=0.
- Reset with we=1 sw addr=0x0 wdata=0xDEADBEEF in the same cycle → memory stays 0, store_cnt=0, ades=0.
